tx_dac_envelope: RTL and testbench
==================================

Name: tx_dac_envelope

Overview:
- Output stage directly downstream of the TX NCO mixer.
- Takes the mixer's 13-bit signed real (I) result and applies a linear ramp-up/ramp-down envelope on PTT edges to prevent key clicks.
- Saturates to 12 bits and drives the AD9866 TX DAC word together with its TX enable.

Parameters:
PRESCALE, 300, clocks per envelope gain step (1..65535); 300 at 76.8 MHz gives about 1 ms per full ramp.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
tx_en  input  1  PTT request, level-sensitive, synchronous to clk
i_data  input  13  signed mixer output, one sample per clk
dac_data  output  12  signed two's-complement DAC word, registered
dac_txen  output  1  DAC transmit enable, registered
clip  output  1  high when the dac_data sample in the same cycle was saturated
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gain=0, prescale counter=0.
  - dac_data=0, dac_txen=0, clip=0, busy=0; pipeline registers cleared.
- gain is 8 bits, 0..255. Value 255 means unity: bypass the multiply and pass i_data directly.
- Prescaler:
  - Counts 0..PRESCALE-1 while in RAMPUP or RAMPDN; a "step" occurs on the cycle it equals PRESCALE-1.
  - Forced to 0 on every state transition and while in IDLE/ON.
- State machine:
  - IDLE: gain=0. tx_en=1 -> RAMPUP.
  - RAMPUP:
    - Each step, gain+1.
    - A step that makes gain 255 -> ON.
    - tx_en=0 -> RAMPDN, keeping the current gain with no jump. This takes priority over a step in the same cycle, so no increment happens.
  - ON: gain held at 255. tx_en=0 -> RAMPDN.
  - RAMPDN:
    - Each step, gain-1.
    - A step that makes gain 0 -> IDLE.
    - tx_en=1 -> RAMPUP from the current gain. This takes priority over a step in the same cycle.
- dac_txen=1 in every state except IDLE. It registers with the state, so it rises 1 clk after tx_en rises from IDLE.
- busy=1 in every state except IDLE, with the same timing as dac_txen.
- Datapath, 2-clock latency from i_data to dac_data:
  - Stage 1:
    - If gain=255: p = i_data sign-extended to 14 bits.
    - Otherwise: p = (i_data * {0,gain} + 128) >>> 8, computed at 22-bit signed width with an arithmetic shift, i.e. round half toward +inf.
    - The gain used is the value registered in the same cycle the sample is captured.
  - Stage 2 saturates p to 12 bits:
    - p > 2047 -> 2047, clip=1.
    - p < -2048 -> -2048, clip=1.
    - Otherwise pass through, clip=0.
    - dac_data and clip are registered together.
- In IDLE, gain=0, so dac_data converges to 0 two clocks after entering IDLE. No explicit blanking is applied.
- Reset mid-ramp returns everything to reset values immediately. The ramp restarts from gain 0 on the next tx_en=1 after reset release.
- tx_en toggling every cycle is legal. Gain never changes by more than 1 per step, never exceeds 255 and never goes below 0.

Test Plan:
- Reset check: assert rst=0 with tx_en=1 and i_data=1000 -> dac_data=0, dac_txen=0, clip=0, busy=0. Release rst -> dac_txen=1 on the 2nd edge after release (state enters RAMPUP on the first).
- Full ramp-up (PRESCALE=4): raise tx_en at cycle 0 -> gain reaches 255 and state is ON after 255*4 cycles. With i_data=1000 held, dac_data rises monotonically to 1000, then is exactly 1000 two clocks after entering ON.
- Rounding: force gain=128 (PRESCALE=4, stop at mid-ramp), i_data=1000 -> 500; i_data=-1 -> 0; i_data=-3 -> -1.
- Saturation in ON:
  - i_data=4095 -> dac_data=2047, clip=1.
  - i_data=-4096 -> dac_data=-2048, clip=1.
  - i_data=2047 -> dac_data=2047, clip=0.
  - Each response appears 2 clocks after the input.
- Ramp reversal (PRESCALE=4):
  - Drop tx_en at gain=100 in RAMPUP -> gain decrements from 100 with no jump; IDLE reached after 100*4 cycles; dac_txen falls 1 clk after IDLE is entered.
  - Re-raise tx_en at gain=50 in RAMPDN -> RAMPUP resumes from 50.
- Reset mid-ramp: pulse rst low at gain=77 in RAMPUP -> all outputs 0 asynchronously. After release with tx_en=1, the ramp restarts from gain 0 and takes 255*PRESCALE cycles to reach ON.

Source files
------------

// File: rtl/tx_dac_envelope_if.sv
// Bus between the TX mixer side and the DAC envelope stage.
// Streaming contract: there is no valid/ready pair. The upstream side presents
// one i_data sample on every clk and the stage accepts it unconditionally;
// dac_data/clip present one result on every clk, two clocks after its sample.
// state and gain are read-only debug views of the envelope controller.
interface tx_dac_envelope_if;
   logic               tx_en;
   logic signed [12:0] i_data;
   logic signed [11:0] dac_data;
   logic               dac_txen;
   logic               clip;
   logic               busy;
   logic [1:0]         state;
   logic [7:0]         gain;

   modport master (
      output tx_en, i_data,
      input  dac_data, dac_txen, clip, busy, state, gain
   );

   modport slave (
      input  tx_en, i_data,
      output dac_data, dac_txen, clip, busy, state, gain
   );
endinterface

// File: rtl/tx_dac_envelope.sv
// TX DAC output stage: linear gain envelope on PTT edges (anti key-click),
// 2-clock multiply/saturate pipeline to the 12-bit AD9866 TX DAC word.
module tx_dac_envelope #(
   parameter int unsigned PRESCALE = 300
) (
   input logic             clk,
   input logic             rst,
   tx_dac_envelope_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, RAMPUP = 2'd1, ON = 2'd2, RAMPDN = 2'd3} state_t;

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   state_t             state, state_nxt;
   logic [7:0]         gain, gain_nxt;
   logic [15:0]        pcnt, pcnt_nxt;
   logic               step;
   logic               txen_d;
   logic signed [21:0] i_ext, g_ext, prod;
   logic signed [13:0] p_nxt, p_reg;
   logic signed [11:0] sat_d;
   logic               clip_d;

   // A gain step is due when the prescaler reaches its last count.
   assign step = (pcnt == PS_LAST);

   assign bus.state = state;
   assign bus.gain  = gain;

   // State, gain and prescaler registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gain  <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         gain  <= gain_nxt;
         pcnt  <= pcnt_nxt;
      end
   end

   // Next-state logic: tx_en changes win over a pending step; gain saturates at 0/255.
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain;
      pcnt_nxt  = '0;
      case (state)
         IDLE: begin
            gain_nxt = '0;
            if (bus.tx_en) state_nxt = RAMPUP;
         end
         RAMPUP: begin
            if (!bus.tx_en) begin
               state_nxt = RAMPDN;
            end else if (step) begin
               if (gain != 8'd255) gain_nxt = gain + 8'd1;
               if (gain >= 8'd254) state_nxt = ON;
            end else begin
               pcnt_nxt = pcnt + 16'd1;
            end
         end
         ON: begin
            gain_nxt = 8'd255;
            if (!bus.tx_en) state_nxt = RAMPDN;
         end
         RAMPDN: begin
            if (bus.tx_en) begin
               state_nxt = RAMPUP;
            end else if (step) begin
               if (gain != 8'd0) gain_nxt = gain - 8'd1;
               if (gain <= 8'd1) state_nxt = IDLE;
            end else begin
               pcnt_nxt = pcnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: transmitter is enabled in every state except IDLE.
   always_comb begin
      txen_d = (state != IDLE);
   end

   // Registered status outputs, one clock behind the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.dac_txen <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.dac_txen <= txen_d;
         bus.busy     <= txen_d;
      end
   end

   // Stage 1 arithmetic: unity gain bypasses the multiply, otherwise round half up.
   always_comb begin
      i_ext = {{9{bus.i_data[12]}}, bus.i_data};
      g_ext = {14'd0, gain};
      prod  = i_ext * g_ext + 22'sd128;
      if (gain == 8'd255) p_nxt = {bus.i_data[12], bus.i_data};
      else                p_nxt = 14'(prod >>> 8);
   end

   // Stage 2 arithmetic: saturate the scaled sample to the 12-bit DAC range.
   always_comb begin
      if (p_reg > 14'sd2047) begin
         sat_d  = 12'h7FF;
         clip_d = 1'b1;
      end else if (p_reg < -14'sd2048) begin
         sat_d  = 12'h800;
         clip_d = 1'b1;
      end else begin
         sat_d  = p_reg[11:0];
         clip_d = 1'b0;
      end
   end

   // Datapath pipeline registers; dac_data and clip always move together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_reg        <= '0;
         bus.dac_data <= '0;
         bus.clip     <= 1'b0;
      end else begin
         p_reg        <= p_nxt;
         bus.dac_data <= sat_d;
         bus.clip     <= clip_d;
      end
   end

endmodule

// File: tb/tb_tx_dac_envelope.sv
// Self-checking bench for tx_dac_envelope with PRESCALE=4.
module tb_tx_dac_envelope;

   localparam int PS = 4;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_DN   = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tx_dac_envelope_if dif();

   tx_dac_envelope #(.PRESCALE(PS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   // ---------------- scoreboard ----------------
   logic [12:0] exp_q[$];
   int          due_q[$];
   int          errors = 0;
   int          checks = 0;
   int          gviol  = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for a cycle and queue its result two clocks later.
   task automatic send(input int din, input int exp_dac, input bit exp_clip);
      dif.i_data = 13'(din);
      exp_q.push_back({exp_clip, 12'(exp_dac)});
      due_q.push_back(cyc + 2);
      tick();
   endtask

   // Step clocks until state (and gain when g >= 0) match, bounded by limit.
   task automatic wait_for(input string name, input logic [1:0] st, input int g, input int limit);
      int n;
      bit hit;
      n   = 0;
      hit = (dif.state == st) && (g < 0 || int'(dif.gain) == g);
      while (!hit && n < limit) begin
         tick();
         n++;
         hit = (dif.state == st) && (g < 0 || int'(dif.gain) == g);
      end
      check(name, int'(hit), 1);
   endtask

   int sat_in  [8] = '{4095, -4096, 2047, -2048, 2048, -2049, 0, -1};
   int sat_out [8] = '{2047, -2048, 2047, -2048, 2047, -2048, 0, -1};
   bit sat_clip[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

   initial begin
      int mark;
      int prev;
      int mono;

      dif.tx_en  = 1'b1;
      dif.i_data = 13'sd1000;

      fork
         // Monitor: pop and compare each queued result when its cycle arrives.
         begin
            logic [12:0] mon_exp;
            int          mon_due;
            forever begin
               @(negedge clk);
               if (due_q.size() > 0 && due_q[0] <= cyc) begin
                  mon_due = due_q.pop_front();
                  mon_exp = exp_q.pop_front();
                  check("sb_cycle", cyc, mon_due);
                  check("sb_dac", int'(dif.dac_data), int'($signed(mon_exp[11:0])));
                  check("sb_clip", int'(dif.clip), int'(mon_exp[12]));
               end
            end
         end
         // Gain may only move by one per clock while out of reset.
         begin
            int gprev;
            gprev = 0;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  gprev = 0;
               end else begin
                  if (int'(dif.gain) > gprev + 1 || gprev > int'(dif.gain) + 1) gviol++;
                  gprev = int'(dif.gain);
               end
            end
         end
         begin
            #1000000;
            $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
            $fatal(1);
         end
      join_none

      // ---- reset values with tx_en=1 and data present ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_dac", int'(dif.dac_data), 0);
      check("rst_txen", int'(dif.dac_txen), 0);
      check("rst_clip", int'(dif.clip), 0);
      check("rst_busy", int'(dif.busy), 0);
      check("rst_gain", int'(dif.gain), 0);
      check("rst_state", int'(dif.state), int'(S_IDLE));

      @(negedge clk);
      #1 rst = 1'b1;
      mark = cyc;
      tick();
      check("rel_e1_state", int'(dif.state), int'(S_UP));
      check("rel_e1_txen", int'(dif.dac_txen), 0);
      tick();
      check("rel_e2_txen", int'(dif.dac_txen), 1);
      check("rel_e2_busy", int'(dif.busy), 1);

      // ---- full ramp-up with i_data=1000 held ----
      prev = int'(dif.dac_data);
      mono = 0;
      while (dif.state != S_ON && cyc - mark < 2000) begin
         tick();
         if (int'(dif.dac_data) < prev) mono++;
         prev = int'(dif.dac_data);
      end
      check("rampup_cycles", cyc - mark, 255 * PS + 1);
      check("on_gain", int'(dif.gain), 255);
      check("rampup_monotonic", mono, 0);
      tick();
      check("on_plus1_dac", int'(dif.dac_data), 992);
      tick();
      check("on_plus2_dac", int'(dif.dac_data), 1000);
      check("on_plus2_clip", int'(dif.clip), 0);

      // ---- saturation at unity gain ----
      for (int i = 0; i < 8; i++) send(sat_in[i], sat_out[i], sat_clip[i]);
      dif.i_data = 13'sd1000;
      repeat (3) tick();

      // ---- full ramp-down from ON ----
      dif.tx_en = 1'b0;
      mark = cyc;
      tick();
      check("dn_from_on_gain", int'(dif.gain), 255);
      wait_for("reach_idle_full", S_IDLE, -1, 2000);
      check("rampdn_cycles", cyc - mark, 255 * PS + 1);
      check("idle_e0_txen", int'(dif.dac_txen), 1);
      tick();
      check("idle_e1_txen", int'(dif.dac_txen), 0);
      check("idle_e1_busy", int'(dif.busy), 0);
      tick();
      check("idle_e2_dac", int'(dif.dac_data), 0);

      // ---- reversal: drop at gain 100 in RAMPUP ----
      dif.tx_en = 1'b1;
      wait_for("reach_up_100", S_UP, 100, 1000);
      dif.tx_en = 1'b0;
      mark = cyc;
      tick();
      check("rev_dn_state", int'(dif.state), int'(S_DN));
      check("rev_dn_gain", int'(dif.gain), 100);
      wait_for("reach_idle_100", S_IDLE, -1, 1000);
      check("rev_idle_cycles", cyc - mark, 100 * PS + 1);
      check("rev_idle_txen_e0", int'(dif.dac_txen), 1);
      tick();
      check("rev_idle_txen_e1", int'(dif.dac_txen), 0);

      // ---- reversal: re-raise at gain 50 in RAMPDN ----
      dif.tx_en = 1'b1;
      wait_for("reach_up_100b", S_UP, 100, 1000);
      dif.tx_en = 1'b0;
      wait_for("reach_dn_50", S_DN, 50, 1000);
      dif.tx_en = 1'b1;
      tick();
      check("resume_state", int'(dif.state), int'(S_UP));
      check("resume_gain", int'(dif.gain), 50);
      repeat (3) tick();
      check("resume_hold_gain", int'(dif.gain), 50);
      tick();
      check("resume_step_gain", int'(dif.gain), 51);

      // ---- reset mid-ramp at gain 77 ----
      wait_for("reach_up_77", S_UP, 77, 1000);
      tick();
      tick();
      check("g77_dac", int'(dif.dac_data), 301);
      #1 rst = 1'b0;
      #1;
      check("midrst_dac", int'(dif.dac_data), 0);
      check("midrst_txen", int'(dif.dac_txen), 0);
      check("midrst_busy", int'(dif.busy), 0);
      check("midrst_clip", int'(dif.clip), 0);
      check("midrst_gain", int'(dif.gain), 0);
      check("midrst_state", int'(dif.state), int'(S_IDLE));
      @(negedge clk);
      #1 rst = 1'b1;
      mark = cyc;

      // ---- rounding at gain 128 during the restarted ramp ----
      wait_for("reach_up_128", S_UP, 128, 1000);
      send(1000, 500, 1'b0);
      send(-1, 0, 1'b0);
      send(-3, -1, 1'b0);
      send(-128, -64, 1'b0);
      dif.i_data = 13'sd1000;

      wait_for("reach_on_restart", S_ON, 255, 2000);
      check("restart_cycles", cyc - mark, 255 * PS + 1);

      repeat (3) tick();
      check("sb_drained", exp_q.size(), 0);
      check("gain_step_violations", gviol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
